// File: rtl/wb_timer_slave_if.sv
// rtl/wb_timer_slave_if.sv - Wishbone slave bus bundle for wb_timer_slave
//
// Purpose: groups the Wishbone classic signals for the timer peripheral.
// Ports (signals):
//   wb_adr_i  [3:0]   byte address, bits [3:2] select the register
//   wb_dat_i  [31:0]  write data
//   wb_dat_o  [31:0]  read data
//   wb_sel_i  [3:0]   write byte enables
//   wb_we_i           write strobe
//   wb_stb_i          strobe
//   wb_cyc_i          cycle valid
//   wb_ack_o          transfer acknowledge
// Modports: master drives the request side, slave drives data/ack back.

interface wb_timer_slave_if;
    logic [3:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_timer_slave.sv
// rtl/wb_timer_slave.sv - prescaled 32-bit timer/compare peripheral on a Wishbone slave port
//
// Purpose: reloadable/one-shot compare timer with a level interrupt.
// Ports:
//   wb_clk_i  in   system clock, all state on rising edge
//   wb_rst_i  in   asynchronous active-high reset
//   wb        slave modport of wb_timer_slave_if (adr/dat/sel/we/stb/cyc in, dat/ack out)
//   int_o     out  registered level interrupt, active-high
// Register map (wb_adr_i[3:2]):
//   0 CTRL    [0] EN, [1] AR, [2] IE, [15:8] PRESCALE
//   1 COUNT   current count
//   2 COMPARE compare value
//   3 STATUS  [0] PEND, write 1 to clear

module wb_timer_slave #(
    parameter logic [7:0]  PRESCALE_RST = 8'h00,
    parameter logic [31:0] COMPARE_RST  = 32'hFFFF_FFFF
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    wb_timer_slave_if.slave  wb,
    output logic             int_o
);

    logic        en_q, ar_q, ie_q, pend_q, ack_q, int_q;
    logic [7:0]  prescale_q, pre_cnt_q;
    logic [31:0] count_q, compare_q, dat_q;

    logic        en_d, ar_d, ie_d, pend_d, int_d;
    logic [7:0]  prescale_d, pre_cnt_d;
    logic [31:0] count_d, compare_d, dat_d;

    logic        access, wr;
    logic        ctrl_wr, count_wr, compare_wr, status_wr;
    logic        tick, hit;
    logic [31:0] rd_data;

    // Byte-offset bits are irrelevant for word registers.
    logic unused_adr;
    assign unused_adr = ^wb.wb_adr_i[1:0];

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  sel);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    // A new access is only taken while ack is low, so each transfer is two cycles.
    assign access     = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
    assign wr         = access & wb.wb_we_i;
    assign ctrl_wr    = wr & (wb.wb_adr_i[3:2] == 2'd0);
    assign count_wr   = wr & (wb.wb_adr_i[3:2] == 2'd1);
    assign compare_wr = wr & (wb.wb_adr_i[3:2] == 2'd2);
    assign status_wr  = wr & (wb.wb_adr_i[3:2] == 2'd3);

    assign tick = en_q & (pre_cnt_q == prescale_q);
    assign hit  = tick & (count_q == compare_q);

    always_comb begin
        rd_data = 32'h0;
        case (wb.wb_adr_i[3:2])
            2'd0: rd_data = {16'h0, prescale_q, 5'b0, ie_q, ar_q, en_q};
            2'd1: rd_data = count_q;
            2'd2: rd_data = compare_q;
            default: rd_data = {31'h0, pend_q};
        endcase
    end

    always_comb begin
        en_d       = en_q;
        ar_d       = ar_q;
        ie_d       = ie_q;
        prescale_d = prescale_q;
        count_d    = count_q;
        compare_d  = compare_q;
        pend_d     = pend_q;
        pre_cnt_d  = pre_cnt_q + 8'd1;

        if (!en_q || tick || ctrl_wr) pre_cnt_d = 8'h0;

        // Timer action first; bus writes below override it where they collide.
        if (hit) begin
            pend_d = 1'b1;
            if (ar_q) count_d = 32'h0;
            else      en_d    = 1'b0;
        end else if (tick) begin
            count_d = count_q + 32'd1;
        end

        if (ctrl_wr) begin
            if (wb.wb_sel_i[0]) begin
                en_d = wb.wb_dat_i[0];
                ar_d = wb.wb_dat_i[1];
                ie_d = wb.wb_dat_i[2];
            end
            if (wb.wb_sel_i[1]) prescale_d = wb.wb_dat_i[15:8];
        end
        if (count_wr)   count_d   = merge_bytes(count_q, wb.wb_dat_i, wb.wb_sel_i);
        if (compare_wr) compare_d = merge_bytes(compare_q, wb.wb_dat_i, wb.wb_sel_i);
        // A compare hit in the same cycle keeps PEND set.
        if (status_wr && wb.wb_sel_i[0] && wb.wb_dat_i[0] && !hit) pend_d = 1'b0;

        int_d = pend_d & ie_d;
        dat_d = (access && !wb.wb_we_i) ? rd_data : 32'h0;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            en_q       <= 1'b0;
            ar_q       <= 1'b0;
            ie_q       <= 1'b0;
            prescale_q <= PRESCALE_RST;
            count_q    <= 32'h0;
            compare_q  <= COMPARE_RST;
            pend_q     <= 1'b0;
            pre_cnt_q  <= 8'h0;
            ack_q      <= 1'b0;
            dat_q      <= 32'h0;
            int_q      <= 1'b0;
        end else begin
            en_q       <= en_d;
            ar_q       <= ar_d;
            ie_q       <= ie_d;
            prescale_q <= prescale_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            pend_q     <= pend_d;
            pre_cnt_q  <= pre_cnt_d;
            ack_q      <= access;
            dat_q      <= dat_d;
            int_q      <= int_d;
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;
    assign int_o       = int_q;

endmodule

// File: tb/tb_wb_timer_slave.sv
// tb/tb_wb_timer_slave.sv - scoreboard bench for wb_timer_slave

module tb_wb_timer_slave;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic int_o;
    int   checks = 0;
    int   failures = 0;

    wb_timer_slave_if bus();

    wb_timer_slave #(
        .PRESCALE_RST(8'h00),
        .COMPARE_RST (32'hFFFF_FFFF)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .wb      (bus),
        .int_o   (int_o)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit          m_en, m_ar, m_ie, m_pend, m_ack, m_int;
    int          m_ps, m_pre;
    logic [31:0] m_count, m_cmp;
    logic [31:0] sb[$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(int rs);
        logic [7:0] ps8;
        ps8 = m_ps[7:0];
        case (rs)
            0: return {16'h0, ps8, 5'b0, m_ie, m_ar, m_en};
            1: return m_count;
            2: return m_cmp;
            default: return {31'h0, m_pend};
        endcase
    endfunction

    task automatic model_reset();
        m_en = 0; m_ar = 0; m_ie = 0; m_pend = 0; m_ack = 0; m_int = 0;
        m_ps = 0; m_pre = 0; m_count = 0; m_cmp = 32'hFFFF_FFFF;
        sb.delete();
    endtask

    task automatic model_step();
        bit acc, wr, tick, hit;
        bit n_en, n_ar, n_ie, n_pend;
        int rs, n_ps, n_pre;
        logic [31:0] n_count, n_cmp, d;
        logic [3:0] s;
        acc = bus.wb_cyc_i && bus.wb_stb_i && !m_ack;
        wr  = acc && bus.wb_we_i;
        rs  = int'(bus.wb_adr_i[3:2]);
        d   = bus.wb_dat_i;
        s   = bus.wb_sel_i;
        if (acc) sb.push_back(bus.wb_we_i ? 32'h0 : m_read(rs));
        tick = m_en && (m_pre == m_ps);
        hit  = tick && (m_count == m_cmp);
        n_en = m_en; n_ar = m_ar; n_ie = m_ie; n_pend = m_pend;
        n_ps = m_ps; n_count = m_count; n_cmp = m_cmp;
        n_pre = (m_en && !tick) ? m_pre + 1 : 0;
        if (hit) begin
            n_pend = 1;
            if (m_ar) n_count = 0; else n_en = 0;
        end else if (tick) begin
            n_count = m_count + 32'd1;
        end
        if (wr) begin
            case (rs)
                0: begin
                    if (s[0]) begin n_en = d[0]; n_ar = d[1]; n_ie = d[2]; end
                    if (s[1]) n_ps = int'(d[15:8]);
                    n_pre = 0;
                end
                1: n_count = merge(m_count, d, s);
                2: n_cmp   = merge(m_cmp, d, s);
                default: if (s[0] && d[0] && !hit) n_pend = 0;
            endcase
        end
        m_en = n_en; m_ar = n_ar; m_ie = n_ie; m_pend = n_pend;
        m_ps = n_ps; m_pre = n_pre; m_count = n_count; m_cmp = n_cmp;
        m_int = n_pend && n_ie;
        m_ack = acc;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // Monitor: compares DUT outputs against the model, pops expected data on ack.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            check("ack", 32'(bus.wb_ack_o), 32'(m_ack));
            check("int_o", 32'(int_o), 32'(m_int));
            if (bus.wb_ack_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'(bus.wb_ack_o), 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("ack_data", bus.wb_dat_o, e);
                end
            end else begin
                check("idle_dat", bus.wb_dat_o, 32'h0);
            end
        end
    end

    task automatic bus_xfer(input logic [3:0] adr, input logic we, input logic [31:0] dat,
                            input logic [3:0] sel, output logic [31:0] rdata);
        bit got;
        got = 0;
        bus.wb_adr_i = adr; bus.wb_we_i = we; bus.wb_dat_i = dat; bus.wb_sel_i = sel;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (bus.wb_ack_o) got = 1;
        end
        rdata = bus.wb_dat_o;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        if (!got) check("ack_timeout", 32'h0, 32'h1);
    endtask

    task automatic wr(input logic [3:0] adr, input logic [31:0] dat);
        logic [31:0] r;
        bus_xfer(adr, 1'b1, dat, 4'hF, r);
    endtask

    task automatic rd_chk(input string name, input logic [3:0] adr, input logic [31:0] exp);
        logic [31:0] r;
        bus_xfer(adr, 1'b0, 32'h0, 4'hF, r);
        check(name, r, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at a negedge where the next rising edge is a compare hit with the bus free.
    task automatic wait_hit(input int max);
        bit found;
        found = 0;
        for (int i = 0; i < max && !found; i++) begin
            if (m_en && m_pre == m_ps && m_count == m_cmp && !m_ack) found = 1;
            else @(negedge clk);
        end
        if (!found) check("hit_timeout", 32'h0, 32'h1);
    endtask

    task automatic wait_int(input int max);
        bit found;
        found = 0;
        for (int i = 0; i < max && !found; i++) begin
            @(negedge clk);
            if (int_o) found = 1;
        end
        if (!found) check("int_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        logic [31:0] r, d, v;
        logic [3:0]  a, s;
        int k;
        bus.wb_adr_i = 0; bus.wb_dat_i = 0; bus.wb_sel_i = 0;
        bus.wb_we_i = 0; bus.wb_stb_i = 0; bus.wb_cyc_i = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset values
        rd_chk("rst_ctrl", 4'h0, 32'h0);
        rd_chk("rst_count", 4'h4, 32'h0);
        rd_chk("rst_compare", 4'h8, 32'hFFFF_FFFF);
        rd_chk("rst_status", 4'hC, 32'h0);

        // Auto-reload every 6 cycles with interrupt
        wr(4'h8, 32'd5);
        wr(4'h0, 32'h0000_0007);
        wait_int(20);
        rd_chk("ar_status", 4'hC, 32'h1);
        wr(4'hC, 32'h1);
        idle(30);
        wr(4'h0, 32'h0);
        wr(4'hC, 32'h1);

        // One-shot with PRESCALE=3
        wr(4'h4, 32'h0);
        wr(4'h8, 32'd2);
        wr(4'h0, 32'h0000_0305);
        idle(40);
        rd_chk("os_ctrl", 4'h0, 32'h0000_0304);
        rd_chk("os_count", 4'h4, 32'd2);
        rd_chk("os_status", 4'hC, 32'h1);
        check("os_int", 32'(int_o), 32'h1);

        // Wrap past 0xFFFF_FFFF without a flag
        wr(4'h0, 32'h0);
        wr(4'hC, 32'h1);
        wr(4'h4, 32'hFFFF_FFFE);
        wr(4'h8, 32'd3);
        wr(4'h0, 32'h0000_0005);
        idle(15);
        rd_chk("wrap_count", 4'h4, 32'd3);
        rd_chk("wrap_ctrl", 4'h0, 32'h0000_0004);
        rd_chk("wrap_status", 4'hC, 32'h1);

        // Collision: STATUS W1C on a hit
        wr(4'h0, 32'h0);
        wr(4'hC, 32'h1);
        wr(4'h4, 32'h0);
        wr(4'h8, 32'd3);
        wr(4'h0, 32'h0000_0003);
        wait_hit(50);
        wr(4'hC, 32'h1);
        rd_chk("col_w1c_status", 4'hC, 32'h1);

        // Collision: COUNT write on a one-shot hit
        wr(4'h0, 32'h0);
        wr(4'hC, 32'h1);
        wr(4'h4, 32'h0);
        wr(4'h8, 32'd3);
        wr(4'h0, 32'h0000_0001);
        wait_hit(50);
        wr(4'h4, 32'h10);
        rd_chk("col_cnt_count", 4'h4, 32'h10);
        rd_chk("col_cnt_status", 4'hC, 32'h1);
        rd_chk("col_cnt_ctrl", 4'h0, 32'h0);

        // Collision: byte-0-only CTRL write on a one-shot hit
        wr(4'hC, 32'h1);
        wr(4'h4, 32'h0);
        wr(4'h8, 32'd2);
        wr(4'h0, 32'h0000_0305);
        wait_hit(60);
        bus_xfer(4'h0, 1'b1, 32'hFFFF_FF00, 4'b0001, r);
        rd_chk("col_ctrl_ctrl", 4'h0, 32'h0000_0300);
        rd_chk("col_ctrl_status", 4'hC, 32'h1);

        // Randomised traffic against the model
        for (int it = 0; it < 300; it++) begin
            k = $urandom_range(0, 9);
            if (k == 0) begin
                bus.wb_cyc_i = $urandom_range(0, 1);
                bus.wb_stb_i = ~bus.wb_cyc_i;
                bus.wb_we_i = 1'b1; bus.wb_sel_i = 4'hF;
                bus.wb_dat_i = $urandom;
                @(negedge clk);
                bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
                continue;
            end
            a = 4'($urandom_range(0, 15));
            s = 4'($urandom_range(0, 15));
            d = $urandom;
            case (a[3:2])
                2'd0: begin
                    v = 32'($urandom_range(0, 3));
                    d[15:8] = v[7:0];
                    d[0] = ($urandom_range(0, 3) != 0);
                end
                2'd1, 2'd2: if ($urandom_range(0, 3) != 0) d = 32'($urandom_range(0, 12));
                default: ;
            endcase
            bus_xfer(a, 1'($urandom_range(0, 1)), d, s, r);
            idle($urandom_range(0, 3));
        end

        // Reset asserted while a write is pending
        wr(4'h0, 32'h0);
        wr(4'hC, 32'h1);
        wr(4'h4, 32'h0);
        wr(4'h8, 32'h0);
        wr(4'h0, 32'h0000_0005);
        idle(3);
        check("pre_rst_int", 32'(int_o), 32'h1);
        bus.wb_adr_i = 4'h8; bus.wb_we_i = 1'b1; bus.wb_dat_i = 32'h1234;
        bus.wb_sel_i = 4'hF; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("rst_ack", 32'(bus.wb_ack_o), 32'h0);
        check("rst_int", 32'(int_o), 32'h0);
        check("rst_dat", bus.wb_dat_o, 32'h0);
        @(negedge clk);
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rd_chk("post_rst_ctrl", 4'h0, 32'h0);
        rd_chk("post_rst_count", 4'h4, 32'h0);
        rd_chk("post_rst_compare", 4'h8, 32'hFFFF_FFFF);
        rd_chk("post_rst_status", 4'hC, 32'h0);
        idle(2);
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
